// File: rtl/ddr_cmd_arbiter.sv
// Round-robin arbiter sharing one DDR burst-command port between NUM_REQ
// requesters, with edge-triggered capture and a stretched per-requester done.
module ddr_cmd_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned ADDR_WIDTH = 30,
  parameter int unsigned NUM_WIDTH  = 28,
  parameter int unsigned DONE_HOLD  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*NUM_WIDTH-1:0]     req_num,
  output logic [NUM_REQ-1:0]               req_done,
  output logic                             cmd_valid,
  input  logic                             cmd_ready,
  output logic [ADDR_WIDTH-1:0]            cmd_addr,
  output logic [NUM_WIDTH-1:0]             cmd_num,
  output logic [ID_WIDTH-1:0]              cmd_id,
  input  logic                             cmd_done,
  output logic                             busy,
  output logic                             err_overrun
);

  localparam int unsigned CNT_W = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    ISSUE = 4'b0010,
    WAIT  = 4'b0100,
    DONE  = 4'b1000
  } state_t;

  state_t                  state;
  logic [NUM_REQ-1:0]      valid_q;
  logic [NUM_REQ-1:0]      pend;
  logic [NUM_REQ-1:0]      req_edge;
  logic [NUM_REQ-1:0]      pend_clr;
  logic [NUM_REQ-1:0]      cur_oh;
  logic [NUM_REQ-1:0]      gnt_oh;
  logic [ADDR_WIDTH-1:0]   held_addr [NUM_REQ];
  logic [NUM_WIDTH-1:0]    held_num  [NUM_REQ];
  logic [ADDR_WIDTH-1:0]   gnt_addr;
  logic [NUM_WIDTH-1:0]    gnt_num;
  logic [ID_WIDTH-1:0]     gnt_id;
  logic [ID_WIDTH-1:0]     last_grant;
  logic                    gnt_found;
  logic [CNT_W-1:0]        hold_cnt;

  assign req_edge = req_valid & ~valid_q;
  assign pend_clr = (state == WAIT && cmd_done) ? cur_oh : '0;

  // Capture runs in every state; a second edge on a pending channel is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      pend        <= '0;
      err_overrun <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        held_addr[i] <= '0;
        held_num[i]  <= '0;
      end
    end else begin
      valid_q     <= req_valid;
      pend        <= (pend & ~pend_clr) | (req_edge & ~pend);
      err_overrun <= err_overrun | (|(req_edge & pend));
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_edge[i] && !pend[i]) begin
          held_addr[i] <= req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          held_num[i]  <= req_num[i*NUM_WIDTH +: NUM_WIDTH];
        end
      end
    end
  end

  // Lowest pending index above last_grant wins; otherwise wrap to the lowest at or below it.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    gnt_oh    = '0;
    gnt_addr  = '0;
    gnt_num   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pend[i] && ID_WIDTH'(i) > last_grant) begin
        gnt_found = 1'b1;
        gnt_id    = ID_WIDTH'(i);
        gnt_oh    = NUM_REQ'(1) << i;
        gnt_addr  = held_addr[i];
        gnt_num   = held_num[i];
      end
    end
    if (!gnt_found) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (pend[i] && ID_WIDTH'(i) <= last_grant) begin
          gnt_found = 1'b1;
          gnt_id    = ID_WIDTH'(i);
          gnt_oh    = NUM_REQ'(1) << i;
          gnt_addr  = held_addr[i];
          gnt_num   = held_num[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cmd_valid  <= 1'b0;
      cmd_addr   <= '0;
      cmd_num    <= '0;
      cmd_id     <= '0;
      cur_oh     <= '0;
      req_done   <= '0;
      hold_cnt   <= '0;
      busy       <= 1'b0;
      last_grant <= ID_WIDTH'(NUM_REQ - 1);
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_found) begin
            cmd_valid <= 1'b1;
            cmd_addr  <= gnt_addr;
            cmd_num   <= gnt_num;
            cmd_id    <= gnt_id;
            cur_oh    <= gnt_oh;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cmd_done) begin
            req_done <= cur_oh;
            hold_cnt <= CNT_W'(DONE_HOLD - 1);
            state    <= DONE;
          end
        end
        DONE: begin
          if (hold_cnt == '0) begin
            req_done   <= '0;
            last_grant <= cmd_id;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// Directed scenarios plus a randomized run against a rule-level model of the arbiter.
module tb_ddr_cmd_arbiter;

  localparam int NR = 4;
  localparam int IW = 2;
  localparam int AW = 30;
  localparam int NW = 28;
  localparam int DH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*NW-1:0]  req_num;
  logic [NR-1:0]     req_done;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [AW-1:0]     cmd_addr;
  logic [NW-1:0]     cmd_num;
  logic [IW-1:0]     cmd_id;
  logic              cmd_done;
  logic              busy;
  logic              err_overrun;

  int checks   = 0;
  int failures = 0;

  ddr_cmd_arbiter #(
    .NUM_REQ(NR), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .NUM_WIDTH(NW), .DONE_HOLD(DH)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_num(req_num),
    .req_done(req_done), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_num(cmd_num), .cmd_id(cmd_id), .cmd_done(cmd_done), .busy(busy),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int ch, input logic [AW-1:0] a, input logic [NW-1:0] n);
    req_addr[ch*AW +: AW] = a;
    req_num[ch*NW +: NW]  = n;
  endtask

  task automatic do_reset();
    req_valid = '0; cmd_ready = 1'b0; cmd_done = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (cmd_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Accept the presented command, then complete it; returns at the first DONE cycle.
  task automatic finish_cmd();
    cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
    tick();
    cmd_done = 1'b1; tick(); cmd_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'b1111; cmd_ready = 1'b1; cmd_done = 1'b1;
    req_addr = {$urandom(), $urandom(), $urandom(), $urandom()};
    req_num  = {$urandom(), $urandom(), $urandom(), $urandom()};
    tick(); tick();
    checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_cmd_valid got=%b exp=0", cmd_valid); end
    checks++; if (req_done !== 4'b0) begin failures++; $display("FAIL reset_req_done got=%b exp=0000", req_done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (err_overrun !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_overrun); end
    checks++; if (cmd_addr !== '0 || cmd_num !== '0 || cmd_id !== '0) begin
      failures++; $display("FAIL reset_cmd_fields got=%h/%h/%0d exp=0/0/0", cmd_addr, cmd_num, cmd_id);
    end
    req_valid = '0; cmd_ready = 1'b0; cmd_done = 1'b0; req_addr = '0; req_num = '0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    set_cmd(1, 30'h0040_0000, 28'd5400);
    req_valid[1] = 1'b1;
    tick();
    checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL single_t1_valid got=%b exp=0", cmd_valid); end
    tick();
    req_valid[1] = 1'b0;
    checks++; if (cmd_valid !== 1'b1 || cmd_id !== 2'd1) begin
      failures++; $display("FAIL single_t2_grant got=%b/%0d exp=1/1", cmd_valid, cmd_id);
    end
    checks++; if (cmd_addr !== 30'h0040_0000 || cmd_num !== 28'd5400) begin
      failures++; $display("FAIL single_payload got=%h/%0d exp=00400000/5400", cmd_addr, cmd_num);
    end
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    checks++; if (cmd_valid !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL single_wait got=%b/%b exp=0/1", cmd_valid, busy);
    end
    tick(); tick();
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      checks++; if (req_done !== ((k <= DH) ? 4'b0010 : 4'b0000)) begin
        failures++; $display("FAIL single_done_c%0d got=%b exp=%b", k, req_done, (k <= DH) ? 4'b0010 : 4'b0000);
      end
      checks++; if (busy !== ((k <= DH) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL single_busy_c%0d got=%b exp=%b", k, busy, (k <= DH) ? 1'b1 : 1'b0);
      end
      tick();
    end
  endtask

  task automatic test_simultaneous();
    int exp_ids [4] = '{0, 2, 3, 0};
    bit ok;
    do_reset();
    for (int c = 0; c < NR; c++) set_cmd(c, AW'(32'h100 * (c + 1)), NW'(c + 7));
    req_valid = 4'b1101;
    tick();
    req_valid = '0;
    for (int n = 0; n < 4; n++) begin
      if (n == 3) begin
        set_cmd(0, 30'h2AB_CDEF, 28'd99);
        req_valid[0] = 1'b1; tick(); req_valid[0] = 1'b0;
      end
      wait_valid(ok);
      checks++; if (!ok || cmd_id !== IW'(exp_ids[n])) begin
        failures++; $display("FAIL simul_grant%0d got=%0d exp=%0d (valid=%b)", n, cmd_id, exp_ids[n], cmd_valid);
      end
      checks++; if (cmd_addr !== ((n == 3) ? 30'h2AB_CDEF : AW'(32'h100 * (exp_ids[n] + 1)))) begin
        failures++; $display("FAIL simul_addr%0d got=%h", n, cmd_addr);
      end
      finish_cmd();
      wait_idle(ok);
      checks++; if (!ok) begin failures++; $display("FAIL simul_idle%0d got=busy exp=idle", n); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    set_cmd(2, 30'h1234_567, 28'd321);
    req_valid[2] = 1'b1; tick(); req_valid[2] = 1'b0;
    wait_valid(ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_present got=0 exp=1"); end
    for (int k = 0; k < 10; k++) begin
      cmd_done = (k == 5);
      tick();
      checks++; if (cmd_valid !== 1'b1 || cmd_addr !== 30'h1234_567 || cmd_id !== 2'd2 || req_done !== 4'b0) begin
        failures++; $display("FAIL bp_stable%0d got=%b/%h/%0d/%b exp=1/01234567/2/0000", k, cmd_valid, cmd_addr, cmd_id, req_done);
      end
    end
    cmd_done = 1'b0;
    cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
    checks++; if (cmd_valid !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL bp_wait got=%b/%b exp=0/1", cmd_valid, busy);
    end
    tick();
    cmd_done = 1'b1; tick(); cmd_done = 1'b0;
    wait_idle(ok);
  endtask

  task automatic test_redone();
    bit ok;
    set_cmd(1, 30'h0AA_0000, 28'd10);
    req_valid[1] = 1'b1; tick(); req_valid[1] = 1'b0;
    wait_valid(ok);
    finish_cmd();
    set_cmd(1, 30'h0BB_0000, 28'd20);
    req_valid[1] = 1'b1; tick(); req_valid[1] = 1'b0;
    wait_valid(ok);
    checks++; if (!ok || cmd_id !== 2'd1 || cmd_addr !== 30'h0BB_0000 || cmd_num !== 28'd20) begin
      failures++; $display("FAIL redone_regrant got=%b/%0d/%h/%0d exp=1/1/00bb0000/20", cmd_valid, cmd_id, cmd_addr, cmd_num);
    end
    checks++; if (err_overrun !== 1'b0) begin failures++; $display("FAIL redone_no_overrun got=%b exp=0", err_overrun); end
    finish_cmd();
    wait_idle(ok);
  endtask

  task automatic test_overrun();
    bit ok;
    set_cmd(2, 30'h0C0_0000, 28'd5);
    req_valid[2] = 1'b1; tick(); req_valid[2] = 1'b0;
    wait_valid(ok);
    cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
    set_cmd(2, 30'h0D0_0000, 28'd6);
    req_valid[2] = 1'b1; tick(); req_valid[2] = 1'b0;
    tick();
    checks++; if (err_overrun !== 1'b1 || cmd_addr !== 30'h0C0_0000) begin
      failures++; $display("FAIL overrun_flag got=%b/%h exp=1/00c00000", err_overrun, cmd_addr);
    end
    cmd_done = 1'b1; tick(); cmd_done = 1'b0;
    wait_idle(ok);
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++; if (cmd_valid !== 1'b0 || err_overrun !== 1'b1) begin
        failures++; $display("FAIL overrun_after%0d got=%b/%b exp=0/1", k, cmd_valid, err_overrun);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    set_cmd(3, 30'h3FF_FFFF, 28'hFFF_FFFF);
    req_valid[3] = 1'b1; tick(); req_valid[3] = 1'b0;
    wait_valid(ok);
    cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (cmd_valid !== 1'b0 || busy !== 1'b0 || req_done !== 4'b0 || err_overrun !== 1'b0 ||
                  cmd_addr !== '0 || cmd_num !== '0 || cmd_id !== '0) begin
      failures++; $display("FAIL rstmid_outputs got=%b/%b/%b/%b/%h/%h/%0d exp=all0",
                           cmd_valid, busy, req_done, err_overrun, cmd_addr, cmd_num, cmd_id);
    end
    cmd_done = 1'b1; tick(); cmd_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++; if (req_done !== 4'b0 || busy !== 1'b0 || cmd_valid !== 1'b0) begin
        failures++; $display("FAIL rstmid_stray%0d got=%b/%b/%b exp=0000/0/0", k, req_done, busy, cmd_valid);
      end
      tick();
    end
  endtask

  // Rule-level model: pending set, round-robin pointer, sticky overrun, done window.
  task automatic test_random();
    int pend_m = 0, pend_old = 0, last_m = NR - 1, cur = 0, done_win = 0, eng_delay = 0, exp_id;
    bit err_m = 0, idle_prev = 1, idle_now, done_end = 0, presenting = 0, eng_has = 0, hs, real_done;
    logic [NR-1:0] drv_v = '0, new_v, edges;
    logic [AW-1:0] held_a [NR];
    logic [NW-1:0] held_n [NR];
    for (int c = 0; c < NR; c++) begin held_a[c] = '0; held_n[c] = '0; end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      if (idle_prev && pend_old != 0) begin
        exp_id = -1;
        for (int s = 1; s <= NR; s++)
          if (exp_id < 0 && ((pend_old >> ((last_m + s) % NR)) & 1) != 0) exp_id = (last_m + s) % NR;
        checks++;
        if (cmd_valid !== 1'b1 || cmd_id !== IW'(exp_id) || cmd_addr !== held_a[exp_id] || cmd_num !== held_n[exp_id]) begin
          failures++; $display("FAIL rnd_grant cyc=%0d got=%b/%0d/%h/%h exp=1/%0d/%h/%h",
                               cyc, cmd_valid, cmd_id, cmd_addr, cmd_num, exp_id, held_a[exp_id], held_n[exp_id]);
        end
        presenting = 1; cur = exp_id;
      end else if (presenting) begin
        checks++;
        if (cmd_valid !== 1'b1 || cmd_id !== IW'(cur) || cmd_addr !== held_a[cur] || cmd_num !== held_n[cur]) begin
          failures++; $display("FAIL rnd_hold cyc=%0d got=%b/%0d/%h exp=1/%0d/%h", cyc, cmd_valid, cmd_id, cmd_addr, cur, held_a[cur]);
        end
      end else begin
        checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL rnd_novalid cyc=%0d got=%b exp=0", cyc, cmd_valid); end
      end
      idle_now = idle_prev && pend_old == 0;
      if (done_win > 0) begin
        checks++; if (req_done !== NR'(1 << cur)) begin
          failures++; $display("FAIL rnd_done cyc=%0d got=%b exp=%b", cyc, req_done, NR'(1 << cur));
        end
        done_win--;
        if (done_win == 0) done_end = 1;
      end else begin
        checks++; if (req_done !== '0) begin failures++; $display("FAIL rnd_nodone cyc=%0d got=%b exp=0000", cyc, req_done); end
        if (done_end) begin idle_now = 1; done_end = 0; end
      end
      checks++; if (busy !== !idle_now) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, !idle_now); end
      checks++; if (err_overrun !== err_m) begin failures++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, err_overrun, err_m); end
      idle_prev = idle_now;
      pend_old  = pend_m;

      for (int c = 0; c < NR; c++) begin
        new_v[c] = ($urandom_range(0, 23) == 0);
        set_cmd(c, AW'($urandom()), NW'($urandom()));
      end
      req_valid = new_v;
      hs = 0;
      if (presenting) begin cmd_ready = ($urandom_range(0, 2) == 0); hs = cmd_ready; end
      else cmd_ready = ($urandom_range(0, 3) == 0);
      if (hs) begin presenting = 0; eng_has = 1; eng_delay = $urandom_range(0, 3); end
      real_done = 0;
      cmd_done  = 1'b0;
      if (eng_has && !hs) begin
        if (eng_delay == 0) begin cmd_done = 1'b1; real_done = 1; eng_has = 0; end
        else eng_delay--;
      end else if (!eng_has) begin
        cmd_done = ($urandom_range(0, 7) == 0);
      end

      edges = new_v & ~drv_v;
      for (int c = 0; c < NR; c++) begin
        if (edges[c]) begin
          if (((pend_m >> c) & 1) != 0) err_m = 1;
          else begin
            pend_m = pend_m | (1 << c);
            held_a[c] = req_addr[c*AW +: AW];
            held_n[c] = req_num[c*NW +: NW];
          end
        end
      end
      if (real_done) begin
        pend_m   = pend_m & ~(1 << cur);
        last_m   = cur;
        done_win = DH;
      end
      drv_v = new_v;
    end
    req_valid = '0; cmd_ready = 1'b0; cmd_done = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_addr = '0; req_num = '0; cmd_ready = 1'b0; cmd_done = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_redone();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr_cmd_arbiter.md
Name: ddr_cmd_arbiter

Overview:
- Shares the single DDR burst-command port between NUM_REQ address controllers, e.g. the rd/wr address generators that each present valid/addr/num and wait for done.
- Captures each requester's command on the rising edge of its valid, grants round-robin, and forwards one command at a time to the DDR burst engine with a valid/ready handshake.
- Returns a stretched done pulse to the owning requester. The stretch lets requesters that synchronise done and edge-detect it see it reliably.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_WIDTH, 2, width of requester index, >= clog2(NUM_REQ)
ADDR_WIDTH, 30, command address width
NUM_WIDTH, 28, burst-length/count width
DONE_HOLD, 4, cycles req_done stays high per completion (>= 1)

Ports:
clk  in  1  single clock; everything is synchronous to it
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester command strobe; a pulse or level, only its rising edge counts
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; slice i = [i*ADDR_WIDTH +: ADDR_WIDTH]
req_num  in  NUM_REQ*NUM_WIDTH  packed counts; same slicing
req_done  out  NUM_REQ  completion to requester i, high for DONE_HOLD cycles
cmd_valid  out  1  command presented to the DDR engine
cmd_ready  in  1  engine accepts the command when high together with cmd_valid
cmd_addr  out  ADDR_WIDTH  granted address
cmd_num  out  NUM_WIDTH  granted count
cmd_id  out  ID_WIDTH  granted requester index
cmd_done  in  1  engine completion pulse for the accepted command
busy  out  1  high in every state except IDLE
err_overrun  out  1  sticky: a request edge arrived on a channel whose command was still pending or active

Behaviour:
Reset values:
- All outputs 0, pending bits 0, state IDLE.
- last_grant = NUM_REQ-1, so requester 0 has first priority.
Capture:
- Register req_valid as valid_q. Edge on channel i is req_valid[i] & ~valid_q[i].
- On an edge with pend[i]=0: set pend[i] and latch the addr/num slice into a per-channel holding register.
- On an edge with pend[i]=1: keep the held command, drop the new one, set err_overrun.
- Capture runs every cycle, in every state, independent of the FSM.
FSM, one-hot, states IDLE, ISSUE, WAIT, DONE:
- IDLE:
  - If any pend bit is set, choose g = first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Load cmd_addr/cmd_num/cmd_id from held[g], set cmd_valid=1, go to ISSUE.
  - If no pend bit is set, stay in IDLE.
- ISSUE:
  - Hold cmd_valid and the cmd_* values stable until cmd_ready=1 is sampled.
  - On that cycle clear cmd_valid on the next edge and go to WAIT.
  - Never retract a command once presented.
- WAIT:
  - On cmd_done=1: clear pend[g], set req_done[g]=1, load the hold counter with DONE_HOLD-1, go to DONE.
  - No timeout.
- DONE:
  - Decrement the hold counter. When it reaches 0, clear req_done[g], set last_grant=g, go to IDLE.
Latency:
- req_valid[i] first high at cycle t → pend[i] visible at t+1 → cmd_valid high at t+2, provided the FSM is in IDLE.
- cmd_done at cycle c → req_done[g] high from c+1 through c+DONE_HOLD.
- IDLE is re-entered at c+DONE_HOLD+1.
Boundary conditions:
- cmd_done outside WAIT: ignored.
- cmd_ready outside ISSUE: ignored.
- A new edge on channel g during DONE: pend[g] is already clear, so it is accepted normally; no overrun.
- A new edge on channel g during ISSUE or WAIT: counts as an overrun.
- Several edges in the same cycle: all are captured.
- Only cmd_id = g is affected by completion; other pend bits never change.
- Reset mid-operation: aborts immediately to reset values. The DDR engine must be reset alongside it, and the arbiter keeps no memory of an in-flight command.
- Address and count pass through unmodified; the arbiter does no arithmetic on them.

Test Plan:
1. Single request: req_valid[1] pulse of 2 cycles at t, addr=0x0040_0000, num=5400 → cmd_valid at t+2 with cmd_id=1; cmd_ready held at 1 → WAIT; cmd_done → req_done[1] high exactly 4 cycles; busy low afterwards.
2. Simultaneous requests: edges on ch 0,2,3 in the same cycle, engine completes each → grant order 0,2,3; then a new ch0 request → grant 0 (wrapped past 3).
3. Backpressure: cmd_ready low for 10 cycles → cmd_valid, cmd_addr and cmd_id stable all 10 cycles, WAIT entered only after the ready cycle.
4. Overrun: second ch2 edge while ch2 is in WAIT with different addr → err_overrun=1 and stays 1; cmd_addr unchanged; after completion no second ch2 command.
5. Re-request during DONE: ch1 edge during the DONE_HOLD window → accepted, no overrun; ch1 re-granted after IDLE if it is the only pending channel.
6. Reset mid-WAIT: rst for 1 cycle → all outputs 0 and pend cleared next cycle; stray cmd_done afterwards → no req_done.
